// File: rtl/scan_chain_ctrl_pkg.sv
// Package for the scan chain controller.
// Holds the controller state encoding, the default value driven on SI while
// unloading, and a helper that sizes the phase bit counter.
package scan_chain_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPT,
        UNLOAD,
        DONE
    } scan_state_t;

    localparam logic DefaultFill = 1'b0;

    // Counter width for a chain of len flops; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned len);
        int unsigned w;
        w = $clog2(len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/scan_shreg.sv
// Parallel-load shift register used to hold the outgoing pattern and collect
// the unloaded chain state.
// Ports:
//   clk_i       clock
//   rst_i       asynchronous active-high reset
//   load_i      parallel load of load_data_i (has priority over shift)
//   load_data_i parallel load value
//   shift_i     shift right by one, ser_i entering at the MSB
//   ser_i       serial input
//   data_o      current register contents
//   ser_o       serial output (bit 0)
module scan_shreg #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic [Width-1:0] data_o,
    output logic             ser_o
);

    logic [Width-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = {ser_i, data_q[Width-1:1]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign ser_o  = data_q[0];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: shifts a parallel pattern into a scan chain, optionally
// fires one capture cycle, then shifts the chain state out into unload_data.
// Ports:
//   CLK         clock shared with the chain flops
//   RST         asynchronous active-high reset
//   start       run request, honoured only in IDLE
//   capt        sampled with start; 1 inserts a capture cycle
//   load_data   pattern, bit i ends up in chain position i (0 = tail)
//   SO          chain tail output
//   SE          registered scan enable
//   SI          registered scan input to the chain head
//   busy        high outside IDLE
//   done        one-cycle pulse when unload_data updates
//   unload_data chain state captured by the last run
module scan_chain_ctrl
    import scan_chain_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 16,
    parameter logic        FILL      = DefaultFill
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 capt,
    input  logic [CHAIN_LEN-1:0] load_data,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] unload_data
);

    localparam int unsigned    CntW   = cnt_width(CHAIN_LEN);
    localparam logic [CntW-1:0] CntMax = CntW'(CHAIN_LEN - 1);

    scan_state_t          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 capt_q, capt_d;
    logic                 se_q, se_d;
    logic                 si_q, si_d;
    logic                 done_q, done_d;
    logic [CHAIN_LEN-1:0] unload_q, unload_d;

    logic [CHAIN_LEN-1:0] shreg;
    logic                 sh_load, sh_shift, sh_ser;
    logic                 sh_tail;
    logic                 last_bit;

    assign last_bit = (cnt_q == CntMax);

    scan_shreg #(
        .Width (CHAIN_LEN)
    ) u_shreg (
        .clk_i       (CLK),
        .rst_i       (RST),
        .load_i      (sh_load),
        .load_data_i (load_data),
        .shift_i     (sh_shift),
        .ser_i       (sh_ser),
        .data_o      (shreg),
        .ser_o       (sh_tail)
    );

    // SE/SI are registered, so each is computed for the state being entered:
    // the chain samples them on the edge that ends that state's cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        capt_d   = capt_q;
        se_d     = 1'b0;
        si_d     = FILL;
        done_d   = 1'b0;
        unload_d = unload_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_ser   = FILL;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    capt_d  = capt;
                    cnt_d   = '0;
                    sh_load = 1'b1;
                    se_d    = 1'b1;
                    si_d    = load_data[0];
                end
            end
            LOAD: begin
                // Chain tail is discarded while loading.
                sh_shift = 1'b1;
                if (last_bit) begin
                    cnt_d = '0;
                    if (capt_q) begin
                        state_d = CAPT;
                    end else begin
                        state_d = UNLOAD;
                        se_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    se_d  = 1'b1;
                    // Next pattern bit is what sits at bit 0 after this shift.
                    si_d  = shreg[1];
                end
            end
            CAPT: begin
                state_d = UNLOAD;
                cnt_d   = '0;
                se_d    = 1'b1;
            end
            UNLOAD: begin
                sh_shift = 1'b1;
                sh_ser   = SO;
                if (last_bit) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    // Take the final shift result directly so data and done align.
                    unload_d = {SO, shreg[CHAIN_LEN-1:1]};
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    se_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            capt_q   <= 1'b0;
            se_q     <= 1'b0;
            si_q     <= 1'b0;
            done_q   <= 1'b0;
            unload_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            capt_q   <= capt_d;
            se_q     <= se_d;
            si_q     <= si_d;
            done_q   <= done_d;
            unload_q <= unload_d;
        end
    end

    assign SE          = se_q;
    assign SI          = si_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);
    assign unload_data = unload_q;

    logic unused_tail;
    assign unused_tail = sh_tail;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: an 8-flop and a 2-flop behavioural scan chain
// whose functional D is the inverse of Q, driven by two controller instances.
module tb_scan_chain_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       capt;
    logic [7:0] load_data;
    logic       so8, se8, si8, busy8, done8;
    logic [7:0] ud8;

    logic       start2;
    logic [1:0] load2;
    logic       so2, se2, si2, busy2, done2;
    logic [1:0] ud2;

    logic [7:0] chain8;
    logic [1:0] chain2;

    int n_checks;
    int n_fail;

    logic       rec_se   [0:40];
    logic       rec_si   [0:40];
    logic       rec_done [0:40];
    logic       rec_busy [0:40];
    logic [7:0] rec_ud   [0:40];

    scan_chain_ctrl #(
        .CHAIN_LEN (8),
        .FILL      (1'b0)
    ) u_dut8 (
        .CLK         (clk),
        .RST         (rst),
        .start       (start),
        .capt        (capt),
        .load_data   (load_data),
        .SO          (so8),
        .SE          (se8),
        .SI          (si8),
        .busy        (busy8),
        .done        (done8),
        .unload_data (ud8)
    );

    scan_chain_ctrl #(
        .CHAIN_LEN (2),
        .FILL      (1'b0)
    ) u_dut2 (
        .CLK         (clk),
        .RST         (rst),
        .start       (start2),
        .capt        (capt),
        .load_data   (load2),
        .SO          (so2),
        .SE          (se2),
        .SI          (si2),
        .busy        (busy2),
        .done        (done2),
        .unload_data (ud2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural chains: SI enters the head, position 0 is the tail.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            chain8 <= '0;
            chain2 <= '0;
        end else begin
            chain8 <= se8 ? {si8, chain8[7:1]} : ~chain8;
            chain2 <= se2 ? {si2, chain2[1]} : ~chain2;
        end
    end
    assign so8 = chain8[0];
    assign so2 = chain2[0];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Starts a run on the 8-bit DUT and records cycles 1..40; start is pulsed
    // again (with inj_pat) during cycles inj_a and inj_b.
    task automatic record_run(input logic [7:0] pat, input logic cp, input int inj_a,
                              input int inj_b, input logic [7:0] inj_pat);
        @(negedge clk);
        load_data = pat;
        capt      = cp;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            rec_se[c]   = se8;
            rec_si[c]   = si8;
            rec_done[c] = done8;
            rec_busy[c] = busy8;
            rec_ud[c]   = ud8;
            if (c == inj_a || c == inj_b) begin
                start     = 1'b1;
                load_data = inj_pat;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    function automatic int nth_done(input int n);
        int seen;
        seen = 0;
        for (int c = 1; c <= 40; c++) begin
            if (rec_done[c]) begin
                seen++;
                if (seen == n) return c;
            end
        end
        return 0;
    endfunction

    function automatic int done_count();
        int cnt;
        cnt = 0;
        for (int c = 1; c <= 40; c++) if (rec_done[c]) cnt++;
        return cnt;
    endfunction

    initial begin
        logic [7:0] pat;
        int         bad;
        int         d;
        int         d2;

        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        capt      = 1'b0;
        load_data = '0;
        start2    = 1'b0;
        load2     = '0;

        #12;
        check_eq("rst_se", se8, 0);
        check_eq("rst_si", si8, 0);
        check_eq("rst_busy", busy8, 0);
        check_eq("rst_done", done8, 0);
        check_eq("rst_ud", ud8, 0);
        @(negedge clk);
        rst = 1'b0;

        // Loopback
        pat = 8'hA5;
        record_run(pat, 1'b0, 0, 0, 8'h00);
        for (int k = 1; k <= 8; k++) check_eq("lb_si", rec_si[k], pat[k-1]);
        bad = 0;
        for (int c = 1; c <= 16; c++) if (!rec_se[c]) bad++;
        check_eq("lb_se_gaps", bad, 0);
        check_eq("lb_se_done", rec_se[17], 0);
        check_eq("lb_done_cyc", nth_done(1), 17);
        check_eq("lb_done_cnt", done_count(), 1);
        check_eq("lb_ud", rec_ud[17], 8'hA5);
        check_eq("lb_busy_done", rec_busy[17], 1);
        check_eq("lb_busy_after", rec_busy[18], 0);

        // Capture: chain inverts itself on the capture edge
        record_run(8'h0F, 1'b1, 0, 0, 8'h00);
        for (int c = 1; c <= 19; c++) check_eq("cap_se", rec_se[c], (c <= 17 && c != 9));
        bad = 0;
        for (int c = 10; c <= 17; c++) if (rec_si[c]) bad++;
        check_eq("cap_si_fill", bad, 0);
        check_eq("cap_done_cyc", nth_done(1), 18);
        check_eq("cap_ud", rec_ud[18], 8'hF0);

        // Start during LOAD and during DONE must be ignored
        record_run(8'h5A, 1'b1, 3, 18, 8'hFF);
        check_eq("ign_done_cnt", done_count(), 1);
        check_eq("ign_done_cyc", nth_done(1), 18);
        check_eq("ign_ud", rec_ud[18], 8'hA5);
        check_eq("ign_busy19", rec_busy[19], 0);

        // Back-to-back: restart in the first IDLE cycle
        record_run(8'h3C, 1'b0, 18, 0, 8'hC3);
        d  = nth_done(1);
        d2 = nth_done(2);
        check_eq("b2b_done_cnt", done_count(), 2);
        check_eq("b2b_done1", d, 17);
        check_eq("b2b_done2", d2, 35);
        check_eq("b2b_ud1", rec_ud[17], 8'h3C);
        check_eq("b2b_ud_hold", rec_ud[34], 8'h3C);
        check_eq("b2b_ud2", rec_ud[35], 8'hC3);

        // Reset during LOAD
        @(negedge clk);
        load_data = 8'hFF;
        capt      = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("prerst_se", se8, 1);
        check_eq("prerst_si", si8, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_se", se8, 0);
        check_eq("arst_si", si8, 0);
        check_eq("arst_busy", busy8, 0);
        check_eq("arst_done", done8, 0);
        check_eq("arst_ud", ud8, 0);
        @(negedge clk);
        rst = 1'b0;
        record_run(8'h81, 1'b0, 0, 0, 8'h00);
        check_eq("post_rst_done_cyc", nth_done(1), 17);
        check_eq("post_rst_ud", rec_ud[17], 8'h81);

        // Two-flop chain
        @(negedge clk);
        load2  = 2'b10;
        capt   = 1'b0;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        d = 0;
        for (int c = 1; c <= 10; c++) begin
            if (done2 && d == 0) begin
                d = c;
                check_eq("w2_ud", ud2, 2'b10);
            end
            @(posedge clk);
            #1;
        end
        check_eq("w2_done_cyc", d, 5);
        check_eq("w2_busy_end", busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Controller that drives the SE/SI side of a scan chain built from the library's scan flip-flops and reads the chain tail (SO) back. It serially loads a parallel test pattern, optionally fires one functional capture clock, and unloads the captured chain state into a parallel register. It sits between a test/BIST sequencer and one scan chain of CHAIN_LEN flops that share CLK.

## Interface
- CHAIN_LEN, 16, number of scan flops in the chain; legal range is 2 and above.
- FILL, 1'b0, value driven on SI during the unload phase.
- CLK  input  1  clock, rising-edge; the same clock feeds the chain flops.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- capt  input  1  sampled together with start; 1 inserts a capture cycle, 0 skips it (loopback).
- load_data  input  CHAIN_LEN  pattern; bit i lands in chain position i (position 0 = tail, drives SO).
- SO  input  1  Q of the chain tail flop.
- SE  output  1  scan enable to every chain flop; registered.
- SI  output  1  scan input to the chain head flop (position CHAIN_LEN-1); registered.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when unload_data is updated.
- unload_data  output  CHAIN_LEN  captured chain state; bit i = value of position i after capture.

## Operation
- States: IDLE, LOAD (CHAIN_LEN cycles), CAPT (1 cycle), UNLOAD (CHAIN_LEN cycles), DONE (1 cycle).
- IDLE: when start=1, latch load_data into the shift register, latch capt, clear the bit counter, and go to LOAD.
- LOAD: SE=1. SI = shreg[0], so the pattern is shifted LSB first. On each edge, shift shreg right and discard SO. When the counter reaches CHAIN_LEN-1, go to CAPT if capt=1, otherwise go to UNLOAD.
- CAPT: SE=0 and SI=FILL. The chain flops load their functional D inputs on the ending edge. Then go to UNLOAD.
- UNLOAD: SE=1 and SI=FILL. On each edge, shift shreg right with SO inserted at the MSB. After CHAIN_LEN edges, shreg[i] holds position i. Then go to DONE.
- DONE: unload_data <= shreg, done=1, then go to IDLE.
- start is ignored in every state except IDLE, including DONE. unload_data holds its value until the next DONE.
- Counter width is $clog2(CHAIN_LEN). The counter wraps to 0 on every phase change and never counts beyond CHAIN_LEN-1.

## Timing
- SE and SI are flop outputs updated on CLK. Chain flops sample them on the following edge.
- SO is sampled on the same edge on which the chain shifts, i.e. before the shift takes effect.
- start is accepted on edge 0. LOAD occupies cycles 1..N and CAPT cycle N+1 (only when capt=1). UNLOAD occupies the next N cycles, followed by DONE.
- done is high in cycle 2N+2 when capt=1 and in cycle 2N+1 when capt=0. busy falls in the cycle after done.
- Reset values: SE=0, SI=0, busy=0, done=0, unload_data=0, state=IDLE, counter=0.
- RST asserted mid-operation aborts immediately and asynchronously to the reset values. Chain contents are then undefined, and no done is issued for the aborted run.
- SE is never 1 in IDLE, CAPT, or DONE.

## Structure
- Package scan_chain_ctrl_pkg holds:
  - the state enum (scan_state_t: IDLE, LOAD, CAPT, UNLOAD, DONE);
  - the default FILL constant;
  - a function returning the counter width for a given CHAIN_LEN.
- One sub-module, scan_shreg: a CHAIN_LEN-bit register with parallel load, right shift with serial in at the MSB, and serial out at bit 0.
- The FSM, counter, and SE/SI/done registers live in the top module.

## Test plan
Bench setup: CHAIN_LEN=8, with a behavioural chain of 8 scan flops (SE-muxed, async reset), each flop's D tied to the inverse of its own Q.
- Loopback: start with capt=0 and load_data=8'hA5 -> SI sequence 1,0,1,0,0,1,0,1 during LOAD with SE=1. done in cycle 17, unload_data=8'hA5, SE never 0 between LOAD and UNLOAD.
- Capture: start with capt=1 and load_data=8'h0F -> SE=0 for exactly cycle 9. done in cycle 18, unload_data=8'hF0. SI=FILL=0 throughout UNLOAD.
- Busy-ignore: start pulses at cycles 3 and 18 (DONE) of a capt=1 run -> no restart, single done pulse, busy=0 in cycle 19.
- Back-to-back: run 8'h3C with capt=0, then start in the first IDLE cycle with 8'hC3 -> done twice, with unload_data 8'h3C and then 8'hC3. unload_data is stable between the two done pulses.
- Reset mid-LOAD: assert RST in cycle 4 between edges -> SE, SI, busy, and done are 0 immediately. A new capt=0 run with 8'h81 completes with unload_data=8'h81.
- Width edge case: CHAIN_LEN=2, capt=0, load_data=2'b10 -> done in cycle 5, unload_data=2'b10.
